stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter LU_CYCLES, default 1, meaning the number of bubble cycles inserted per load-use hazard (legal range 1..7).
REQ-002 SHALL have parameter WDOG_LIMIT, default 64, meaning the maximum number of consecutive EX-busy cycles before a forced release (legal range 2..255).
REQ-003 SHALL have port clk, input, 1, the single clock; every register samples on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous and active-low.
REQ-005 SHALL have port stallreq_id, input, 1, the load-use hazard request from the ID stage.
REQ-006 SHALL have port stallreq_ex, input, 1, the multi-cycle EX operation (divide) busy request.
REQ-007 SHALL have port ex_done, input, 1, a one-cycle pulse marking EX operation completion.
REQ-008 SHALL have port stall, output, 6, the stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-009 SHALL have port stall_cycles, output, 32, the count of cycles in which stall != 0.
REQ-010 SHALL have port wdog_err, output, 1, sticky flag indicating that the watchdog fired.

Function
REQ-011 SHALL implement FSM states RUN, LU and EXBUSY; stall SHALL be a combinational function of the state and the requests, so it responds in the same cycle as a request.
REQ-012 In RUN with stallreq_ex=1, stall SHALL be 6'b001111 and the next state SHALL be EXBUSY; stallreq_ex SHALL take priority over stallreq_id.
REQ-013 In RUN with only stallreq_id=1, stall SHALL be 6'b000111 (ID->EX bubble), the bubble counter SHALL load LU_CYCLES-1, and the next state SHALL be LU if LU_CYCLES>1, else RUN.
REQ-014 In LU, stall SHALL be 6'b000111 and the counter SHALL decrement each cycle; the FSM SHALL return to RUN after the cycle in which the counter equals 0.
REQ-015 In LU, if stallreq_ex rises, stall SHALL become 6'b001111 and the next state SHALL be EXBUSY, abandoning the remaining bubbles.
REQ-016 In EXBUSY, stall SHALL be 6'b001111 until ex_done=1; in the ex_done cycle stall SHALL be 6'b000000 and the next state SHALL be RUN.
REQ-017 An ex_done pulse while in RUN or LU SHALL be ignored.
REQ-018 In RUN with no request, stall SHALL be 6'b000000.
REQ-019 stall_cycles SHALL increment by 1 in every cycle where stall != 0, SHALL wrap from 32'hFFFFFFFF to 0, and SHALL never saturate.

Reset
REQ-020 Asserting rst (low) SHALL immediately force state=RUN, bubble counter=0, watchdog counter=0, stall_cycles=0 and wdog_err=0.
REQ-021 While rst is low, stall SHALL be 6'b000000 regardless of the request inputs.
REQ-022 Reset asserted mid-EXBUSY or mid-LU SHALL abandon the operation, with no residual stall after release.
REQ-023 The first request SHALL be honoured in the first clock edge after rst deasserts.

Configuration
REQ-024 Macro STALL_CTRL_WDOG_EN defined: an 8-bit watchdog SHALL count EXBUSY cycles and clear on leaving EXBUSY.
REQ-025 When the watchdog count reaches WDOG_LIMIT-1, the FSM SHALL force RUN on the next edge and set wdog_err=1 until reset.
REQ-026 Macro STALL_CTRL_WDOG_EN undefined: no watchdog logic SHALL exist, wdog_err SHALL be tied to 0, and EXBUSY SHALL wait indefinitely for ex_done.

Structure
REQ-027 The shared package stall_ctrl_pkg SHALL hold the FSM state encoding, the StallBus width (6) and the stall constants STALL_NONE=6'b000000, STALL_ID=6'b000111 and STALL_EX=6'b001111.
REQ-028 The watchdog SHALL be the single sub-module stall_wdog, instantiated only under STALL_CTRL_WDOG_EN.

Verification
REQ-029 Scenario: stallreq_id single-cycle pulse, LU_CYCLES=1 -> stall=000111 for exactly 1 cycle, then 000000; stall_cycles=1.
REQ-030 Scenario: stallreq_id pulse, LU_CYCLES=3 -> stall=000111 for 3 consecutive cycles, then RUN; stall_cycles=3.
REQ-031 Scenario: stallreq_id and stallreq_ex asserted together, ex_done after 10 cycles -> stall=001111 for 10 cycles, 000000 in the ex_done cycle, and the ID bubble is not inserted.
REQ-032 Scenario: with the macro defined, WDOG_LIMIT=64, stallreq_ex held and ex_done never asserted -> stall=001111 for 64 cycles, then RUN; wdog_err=1 and stays 1.
REQ-033 Scenario: rst driven low mid-EXBUSY between clock edges -> stall=000000 immediately; stall_cycles=0 and state RUN after release.
REQ-034 Scenario: stall_cycles preloaded to 32'hFFFFFFFE via force, then 3 stalled cycles -> value 32'h00000001.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall controller:
//                FSM state encoding, stall bus width and stall patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package stall_ctrl_pkg;

    // Stall bus: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop
    localparam int STALL_BUS_W = 6;
    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    // Watchdog counter width
    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LU     = 2'd1,
        EXBUSY = 2'd2
    } state_t;

endpackage : stall_ctrl_pkg
`default_nettype wire

// File: rtl/stall_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : stall_wdog
//  Description : EX-busy watchdog. Counts consecutive EX stall cycles and
//                fires once the count reaches WDOG_LIMIT-1; the error flag is
//                sticky until reset. Compiled only when STALL_CTRL_WDOG_EN is
//                defined, so the default build carries no watchdog logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef STALL_CTRL_WDOG_EN
module stall_wdog
    import stall_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 64
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic exbusy,     // FSM currently in EXBUSY
    input  logic hold,       // EX stall continues into the next cycle
    output logic fire,       // force the FSM back to RUN on the next edge
    output logic err         // sticky watchdog error
);

    localparam logic [WDOG_W-1:0] c_fire_at = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] r_cnt;
    logic              r_err;

    assign fire = exbusy && (r_cnt == c_fire_at);
    assign err  = r_err;

    // Count every edge that keeps the EX stall alive (entry edge included);
    // clear when the stall ends or the watchdog fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (fire || !hold) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (fire) begin
            r_err <= 1'b1;
        end
    end

endmodule : stall_wdog
`endif
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Pipeline stall controller. Inserts LU_CYCLES ID->EX bubbles
//                per load-use hazard and holds PC..EX while a multi-cycle EX
//                operation is busy. Counts stalled cycles. Optional EX-busy
//                watchdog enabled by macro STALL_CTRL_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int LU_CYCLES  = 1,
    parameter int WDOG_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   rst,          // asynchronous, active-low
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   ex_done,
    output logic [STALL_BUS_W-1:0] stall,
    output logic [31:0]            stall_cycles,
    output logic                   wdog_err
);

    localparam logic [2:0] c_lu_load = 3'(LU_CYCLES - 1);

    if (LU_CYCLES < 1 || LU_CYCLES > 7) begin : g_check_lu
        $error("stall_ctrl: LU_CYCLES out of range 1..7");
    end
    if (WDOG_LIMIT < 2 || WDOG_LIMIT > 255) begin : g_check_wdog
        $error("stall_ctrl: WDOG_LIMIT out of range 2..255");
    end

    state_t     r_state;
    state_t     w_next_pre;
    state_t     w_next;
    logic [2:0] r_bubble;
    logic [2:0] w_bubble_next;
    stall_bus_t w_stall;
    logic [31:0] r_stall_cycles;

    // Next state, bubble count and stall pattern from state and requests
    always_comb begin
        w_next_pre    = r_state;
        w_bubble_next = r_bubble;
        w_stall       = STALL_NONE;
        case (r_state)
            RUN: begin
                if (stallreq_ex) begin
                    w_stall    = STALL_EX;
                    w_next_pre = EXBUSY;
                end else if (stallreq_id) begin
                    w_stall       = STALL_ID;
                    w_bubble_next = c_lu_load;
                    w_next_pre    = (LU_CYCLES > 1) ? LU : RUN;
                end
            end
            LU: begin
                if (stallreq_ex) begin
                    // EX busy wins; remaining bubbles are dropped
                    w_stall       = STALL_EX;
                    w_bubble_next = '0;
                    w_next_pre    = EXBUSY;
                end else begin
                    // The bubble that drains the counter to zero is the last one
                    w_stall       = STALL_ID;
                    w_bubble_next = r_bubble - 3'd1;
                    if (r_bubble <= 3'd1) begin
                        w_next_pre = RUN;
                    end
                end
            end
            EXBUSY: begin
                if (ex_done) begin
                    w_next_pre = RUN;
                end else begin
                    w_stall = STALL_EX;
                end
            end
            default: begin
                w_next_pre = RUN;
            end
        endcase
    end

`ifdef STALL_CTRL_WDOG_EN
    logic w_wdog_fire;

    stall_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .exbusy (r_state == EXBUSY),
        .hold   (w_next_pre == EXBUSY),
        .fire   (w_wdog_fire),
        .err    (wdog_err)
    );

    assign w_next = w_wdog_fire ? RUN : w_next_pre;
`else
    assign w_next   = w_next_pre;
    assign wdog_err = 1'b0;
`endif

    // Stall is forced quiet while reset is held, whatever the requests do
    assign stall        = rst ? w_stall : STALL_NONE;
    assign stall_cycles = r_stall_cycles;

    // FSM state and bubble counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_bubble <= '0;
        end else begin
            r_state  <= w_next;
            r_bubble <= w_bubble_next;
        end
    end

    // Free-running stalled-cycle counter; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (stall != STALL_NONE) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule : stall_ctrl
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stall_ctrl
//  Description : Self-checking bench for stall_ctrl. Two instances share the
//                inputs: dut_a with LU_CYCLES=1, dut_b with LU_CYCLES=3.
//                Expected stall pairs are queued as stimulus is applied and
//                popped when the combinational output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_ID   = 6'b000111;
    localparam logic [5:0] E_EX   = 6'b001111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        ex_done = 1'b0;
    logic [5:0]  stall_a, stall_b;
    logic [31:0] cyc_a, cyc_b;
    logic        err_a, err_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    exp_t q_exp[$];

    always #5 clk = ~clk;

    stall_ctrl #(.LU_CYCLES(1), .WDOG_LIMIT(64)) dut_a (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .ex_done(ex_done), .stall(stall_a), .stall_cycles(cyc_a), .wdog_err(err_a)
    );

    stall_ctrl #(.LU_CYCLES(3), .WDOG_LIMIT(64)) dut_b (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .ex_done(ex_done), .stall(stall_b), .stall_cycles(cyc_b), .wdog_err(err_b)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; ex_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [5:0] ex_a [4] = '{E_EX, E_EX, E_NONE, E_NONE};
        logic       ex_v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       dn_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        rst = 1'b0; stallreq_id = 1'b1; stallreq_ex = 1'b1;
        #1;
        checks++; if (stall_a !== E_NONE) begin failures++; $display("FAIL reset_stall_a got=%b exp=%b", stall_a, E_NONE); end
        checks++; if (stall_b !== E_NONE) begin failures++; $display("FAIL reset_stall_b got=%b exp=%b", stall_b, E_NONE); end
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%h exp=0", cyc_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_wdog_err got=%b exp=0", err_a); end
        @(negedge clk);
        #1;
        checks++; if (stall_a !== E_NONE) begin failures++; $display("FAIL reset_held_stall got=%b exp=%b", stall_a, E_NONE); end
        // First request after release must be taken on the first edge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b1; stallreq_id = (i == 0); stallreq_ex = ex_v[i]; ex_done = dn_v[i];
            q_exp.push_back('{a: ex_a[i], b: ex_a[i]});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL first_req_a cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL first_req_b cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'd2) begin failures++; $display("FAIL first_req_cycles got=%0d exp=2", cyc_a); end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [5:0] ea [5] = '{E_ID, E_NONE, E_NONE, E_NONE, E_NONE};
        logic [5:0] eb [5] = '{E_ID, E_ID, E_ID, E_NONE, E_NONE};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stallreq_id = (i == 0); stallreq_ex = 1'b0; ex_done = 1'b0;
            q_exp.push_back('{a: ea[i], b: eb[i]});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL lu1_stall cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL lu3_stall cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'd1) begin failures++; $display("FAIL lu1_cycles got=%0d exp=1", cyc_a); end
        checks++; if (cyc_b !== 32'd3) begin failures++; $display("FAIL lu3_cycles got=%0d exp=3", cyc_b); end
    endtask

    task automatic test_preempt_and_ignore();
        exp_t e;
        logic       id_v [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ex_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       dn_v [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] ea   [7] = '{E_NONE, E_ID, E_NONE, E_EX, E_EX, E_NONE, E_NONE};
        logic [5:0] eb   [7] = '{E_NONE, E_ID, E_ID, E_EX, E_EX, E_NONE, E_NONE};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            stallreq_id = id_v[i]; stallreq_ex = ex_v[i]; ex_done = dn_v[i];
            q_exp.push_back('{a: ea[i], b: eb[i]});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL preempt_a cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL preempt_b cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'd3) begin failures++; $display("FAIL preempt_cycles_a got=%0d exp=3", cyc_a); end
        checks++; if (cyc_b !== 32'd4) begin failures++; $display("FAIL preempt_cycles_b got=%0d exp=4", cyc_b); end
    endtask

    task automatic test_ex_priority();
        exp_t e;
        logic [5:0] x;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            stallreq_id = (i == 0); stallreq_ex = (i < 10); ex_done = (i == 10);
            x = (i < 10) ? E_EX : E_NONE;
            q_exp.push_back('{a: x, b: x});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL ex_prio_a cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL ex_prio_b cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'd10) begin failures++; $display("FAIL ex_prio_cycles_a got=%0d exp=10", cyc_a); end
        checks++; if (cyc_b !== 32'd10) begin failures++; $display("FAIL ex_prio_cycles_b got=%0d exp=10", cyc_b); end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [5:0] ea [4] = '{E_ID, E_ID, E_ID, E_NONE};
        apply_reset();
        @(negedge clk);
        force dut_a.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut_a.r_stall_cycles;
        #1;
        checks++; if (cyc_a !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_preload got=%h exp=fffffffe", cyc_a); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stallreq_id = (i < 3); stallreq_ex = 1'b0; ex_done = 1'b0;
            q_exp.push_back('{a: ea[i], b: ea[i]});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL wrap_stall_a cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL wrap_stall_b cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'h0000_0001) begin failures++; $display("FAIL wrap_value got=%h exp=00000001", cyc_a); end
        checks++; if (cyc_b !== 32'd3) begin failures++; $display("FAIL wrap_ref_b got=%0d exp=3", cyc_b); end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        apply_reset();
        // Mid-EXBUSY: reset between edges with the request still high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stallreq_ex = 1'b1;
            q_exp.push_back('{a: E_EX, b: E_EX});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (stall_a !== E_NONE) begin failures++; $display("FAIL midrst_ex_stall got=%b exp=%b", stall_a, E_NONE); end
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL midrst_ex_cycles got=%0d exp=0", cyc_a); end
        @(negedge clk);
        stallreq_ex = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            q_exp.push_back('{a: E_NONE, b: E_NONE});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL midrst_ex_after_a cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL midrst_ex_after_b cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL midrst_ex_after_cycles got=%0d exp=0", cyc_a); end
        // Mid-LU on dut_b
        @(negedge clk);
        stallreq_id = 1'b1;
        @(negedge clk);
        stallreq_id = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (stall_b !== E_NONE) begin failures++; $display("FAIL midrst_lu_stall got=%b exp=%b", stall_b, E_NONE); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            q_exp.push_back('{a: E_NONE, b: E_NONE});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_b !== e.b) begin failures++; $display("FAIL midrst_lu_after cyc=%0d got=%b exp=%b", i, stall_b, e.b); end
        end
        checks++; if (cyc_b !== 32'd0) begin failures++; $display("FAIL midrst_lu_cycles got=%0d exp=0", cyc_b); end
    endtask

    task automatic test_watchdog();
        exp_t e;
        logic [5:0] x;
        apply_reset();
`ifdef STALL_CTRL_WDOG_EN
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            stallreq_ex = (i < 64); ex_done = 1'b0; stallreq_id = 1'b0;
            x = (i < 64) ? E_EX : E_NONE;
            q_exp.push_back('{a: x, b: x});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL wdog_stall cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
            if (i == 63) begin
                checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL wdog_err_early got=%b exp=0", err_a); end
            end
        end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL wdog_err_set got=%b exp=1", err_a); end
        checks++; if (cyc_a !== 32'd64) begin failures++; $display("FAIL wdog_cycles got=%0d exp=64", cyc_a); end
        repeat (5) @(negedge clk);
        checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL wdog_err_sticky got=%b exp=1", err_b); end
        apply_reset();
        #1;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL wdog_err_cleared got=%b exp=0", err_a); end
`else
        for (int i = 0; i < 102; i++) begin
            @(negedge clk);
            stallreq_ex = (i < 100); ex_done = (i == 100); stallreq_id = 1'b0;
            x = (i < 100) ? E_EX : E_NONE;
            q_exp.push_back('{a: x, b: x});
            #1;
            e = q_exp.pop_front();
            checks++; if (stall_a !== e.a) begin failures++; $display("FAIL nowdog_stall cyc=%0d got=%b exp=%b", i, stall_a, e.a); end
        end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL nowdog_err got=%b exp=0", err_a); end
        checks++; if (cyc_a !== 32'd100) begin failures++; $display("FAIL nowdog_cycles got=%0d exp=100", cyc_a); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_preempt_and_ignore();
        test_ex_priority();
        test_wrap();
        test_mid_reset();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stall_ctrl
`default_nettype wire
